// File: rtl/timer_counter_pkg.sv
// ---------------------------------------------------------------------------
// timer_counter_pkg
//
// Shared definitions for the memory-mapped countdown timer:
//   - word offsets of the three bus-visible registers (addr = bus addr[3:2])
//   - FSM state encoding
//   - CTRL bit positions (EN, MODE, IM, PS)
//   - MODE field constants
// ---------------------------------------------------------------------------
package timer_counter_pkg;

  // Register word offsets; offset 3 is unmapped and reads as zero.
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  // CTRL bit positions. MODE occupies [2:1], PS occupies [7:4].
  localparam int TC_CTRL_EN      = 0;
  localparam int TC_CTRL_MODE_LO = 1;
  localparam int TC_CTRL_IM      = 3;
  localparam int TC_CTRL_PS_LO   = 4;

  // MODE field values. Encodings 10 and 11 behave as one-shot.
  localparam logic [1:0] TC_MODE0 = 2'b00;
  localparam logic [1:0] TC_MODE1 = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_t;

endpackage

// File: rtl/tc_prescaler.sv
// ---------------------------------------------------------------------------
// tc_prescaler
//
// Free-running tick generator for the timer's optional prescaler. A tick is
// produced when the internal counter equals (1 << ps) - 1, after which the
// counter wraps to zero, so ps = 0 ticks every cycle.
//
// The whole module only exists when TC_PRESCALE_EN is defined, since it is
// instantiated nowhere else in the default build.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   clear  in   restart the divider (asserted while the timer is in LOAD)
//   ps     in   4-bit prescale exponent
//   tick   out  one-cycle enable for the countdown
// ---------------------------------------------------------------------------
`ifdef TC_PRESCALE_EN
module tc_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] ps,
  output logic       tick
);

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] target;

  always_comb begin
    target = (PRESCALE_W'(1) << ps) - PRESCALE_W'(1);
  end

  assign tick = (cnt == target);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule
`endif

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped countdown timer on the CPU bridge bus. Its irq output feeds
// one bit of the coprocessor-0 HWInt vector.
//
// Registers (word offsets on addr):
//   0 CTRL   [0] EN, [2:1] MODE, [3] IM, [7:4] PS (prescaler builds only)
//   1 PRESET reload value, used at the next LOAD
//   2 COUNT  current count, read-only
//   3 unmapped, reads 0, writes ignored
//
// Mode 0 (one-shot): irq_flag is sticky until the next CTRL write and EN is
// cleared when the count expires. Mode 1 (auto-reload): irq_flag is a
// one-cycle pulse and the count restarts via LOAD.
//
// Optional feature macro: TC_PRESCALE_EN. When defined, CTRL.PS is stored
// and the countdown advances only on tc_prescaler ticks.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   addr   in   [1:0]  word offset (bus address bits [3:2])
//   we     in   write enable, sampled at posedge clk
//   wd     in   [31:0] write data
//   rd     out  [31:0] combinational read data for addr
//   irq    out  interrupt request = irq_flag & CTRL.IM
// ---------------------------------------------------------------------------
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] INIT_PRESET = 32'h0,
  parameter int          PRESCALE_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  // The largest prescale target, (1 << 15) - 1, needs 15 bits.
  if (PRESCALE_W < 15) begin : g_prescale_w_check
    $error("PRESCALE_W must be at least 15");
  end

  tc_state_t   state;
  logic [3:0]  ctrl_lo;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        tick;
  logic [3:0]  ps_view;
  logic        ctrl_write;

  assign ctrl_write = we && (addr == TC_CTRL);

`ifdef TC_PRESCALE_EN
  logic [3:0] ps_q;
  logic       load_state;

  assign load_state = (state == TC_LOAD);
  assign ps_view    = ps_q;

  tc_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(load_state),
    .ps   (ps_q),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= 4'h0;
    end else if (ctrl_write) begin
      ps_q <= wd[TC_CTRL_PS_LO +: 4];
    end
  end
`else
  assign ps_view = 4'h0;
  assign tick    = 1'b1;
`endif

  // FSM plus register file. CPU writes are applied after the FSM updates so
  // that a CTRL write overrides INT's EN clear and also cancels an irq_flag
  // being set on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TC_IDLE;
      ctrl_lo  <= 4'h0;
      preset   <= INIT_PRESET;
      count    <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        TC_IDLE: begin
          if (ctrl_lo[TC_CTRL_EN]) begin
            state <= TC_LOAD;
          end
        end
        TC_LOAD: begin
          count <= preset;
          state <= TC_CNT;
        end
        TC_CNT: begin
          if (!ctrl_lo[TC_CTRL_EN]) begin
            state <= TC_IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= 32'h0;
              irq_flag <= 1'b1;
              state    <= TC_INT;
            end
          end
        end
        TC_INT: begin
          // MODE is sampled here, so a mid-count MODE change takes effect now.
          if (ctrl_lo[TC_CTRL_MODE_LO +: 2] == TC_MODE1) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl_lo[TC_CTRL_EN] <= 1'b0;
          end
          state <= TC_IDLE;
        end
        default: state <= TC_IDLE;
      endcase

      if (ctrl_write) begin
        ctrl_lo  <= wd[3:0];
        irq_flag <= 1'b0;
      end
      if (we && (addr == TC_PRESET)) begin
        preset <= wd;
      end
    end
  end

  always_comb begin
    rd = 32'h0;
    case (addr)
      TC_CTRL:   rd = {24'h0, ps_view, ctrl_lo};
      TC_PRESET: rd = preset;
      TC_COUNT:  rd = count;
      default:   rd = 32'h0;
    endcase
  end

  assign irq = irq_flag & ctrl_lo[TC_CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
//
// Directed, self-checking bench for timer_counter. Inputs are driven 1 ns
// after the rising edge and outputs are sampled there too. "Edge +k" below
// counts rising edges after the edge that performed the CTRL write.
// ---------------------------------------------------------------------------
module tb_timer_counter;

  localparam logic [31:0] INIT = 32'h0000_0007;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checks;
  int errors;
  logic [31:0] v;

  timer_counter #(
    .INIT_PRESET(INIT),
    .PRESCALE_W (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic check_regs_reset(input string tag);
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL %s_ctrl: got %h expected %h", tag, v, 32'h0);
    end
    read_reg(2'd1, v);
    checks++;
    if (v !== INIT) begin
      errors++;
      $display("[TB] FAIL %s_preset: got %h expected %h", tag, v, INIT);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL %s_count: got %h expected %h", tag, v, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_irq: got %b expected 0", tag, irq);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_edges(2);
    reset = 1'b0;
    check_regs_reset("reset");
    read_reg(2'd3, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_unmapped: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_mode0();
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      wait_edges(1);
      if (k >= 2) begin
        read_reg(2'd2, v);
        checks++;
        if (v !== 32'(7 - k)) begin
          errors++;
          $display("[TB] FAIL mode0_count_e%0d: got %0d expected %0d", k, v, 7 - k);
        end
      end
      checks++;
      if (irq !== (k == 7)) begin
        errors++;
        $display("[TB] FAIL mode0_irq_e%0d: got %b expected %b", k, irq, (k == 7));
      end
    end
    wait_edges(1);
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("[TB] FAIL mode0_ctrl_en_cleared: got %h expected %h", v, 32'h8);
    end
    wait_edges(3);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mode0_irq_sticky: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mode0_irq_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_mode1();
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      wait_edges(1);
      checks++;
      if (irq !== (k == 7 || k == 15 || k == 23)) begin
        errors++;
        $display("[TB] FAIL mode1_irq_e%0d: got %b expected %b", k, irq,
                 (k == 7 || k == 15 || k == 23));
      end
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'hB) begin
      errors++;
      $display("[TB] FAIL mode1_ctrl_en_kept: got %h expected %h", v, 32'hB);
    end
    bus_write(2'd0, 32'h0);
    wait_edges(4);
  endtask

  task automatic test_im_masked();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h1);
    for (int k = 1; k <= 7; k++) begin
      wait_edges(1);
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("[TB] FAIL masked_irq_e%0d: got %b expected 0", k, irq);
      end
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL masked_ctrl_en_cleared: got %h expected %h", v, 32'h0);
    end
    bus_write(2'd0, 32'h8);
    wait_edges(2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL masked_flag_cleared: got %b expected 0", irq);
    end
  endtask

  task automatic test_preset_zero();
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      wait_edges(1);
      checks++;
      if (irq !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL preset0_irq_e%0d: got %b expected %b", k, irq, (k == 3));
      end
    end
    bus_write(2'd0, 32'h8);
    wait_edges(1);
  endtask

  task automatic test_count_write();
    bus_write(2'd2, 32'h1234);
    bus_write(2'd3, 32'h5678);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL count_readonly: got %h expected %h", v, 32'h0);
    end
    read_reg(2'd1, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL unmapped_write_preset: got %h expected %h", v, 32'h0);
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("[TB] FAIL unmapped_write_ctrl: got %h expected %h", v, 32'h8);
    end
  endtask

  task automatic test_freeze();
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    wait_edges(3);
    bus_write(2'd0, 32'h8);
    wait_edges(5);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'd8) begin
      errors++;
      $display("[TB] FAIL freeze_count: got %0d expected %0d", v, 8);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL freeze_irq: got %b expected 0", irq);
    end
    bus_write(2'd0, 32'h9);
    wait_edges(2);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("[TB] FAIL reenable_reload: got %0d expected %0d", v, 10);
    end
    bus_write(2'd0, 32'h8);
    wait_edges(3);
  endtask

  task automatic test_back_to_back();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    wait_edges(3);
    bus_write(2'd0, 32'h9);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_vs_flag_set: got %b expected 0", irq);
    end
    bus_write(2'd0, 32'h9);
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h9) begin
      errors++;
      $display("[TB] FAIL write_vs_en_clear: got %h expected %h", v, 32'h9);
    end
    wait_edges(3);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_irq_early: got %b expected 0", irq);
    end
    wait_edges(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_irq: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h8);
    wait_edges(2);
  endtask

  task automatic test_mode_change();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    wait_edges(2);
    bus_write(2'd0, 32'h9);
    wait_edges(2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL modechg_irq_set: got %b expected 1", irq);
    end
    wait_edges(2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL modechg_irq_sticky: got %b expected 1", irq);
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("[TB] FAIL modechg_ctrl: got %h expected %h", v, 32'h8);
    end
    bus_write(2'd0, 32'h8);
  endtask

  task automatic test_reset_midcount();
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'h9);
    wait_edges(5);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'd17) begin
      errors++;
      $display("[TB] FAIL midcount_count: got %0d expected %0d", v, 17);
    end
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    check_regs_reset("midreset");
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h9);
    wait_edges(4);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prereset_irq: got %b expected 1", irq);
    end
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    check_regs_reset("irqreset");
  endtask

`ifdef TC_PRESCALE_EN
  task automatic test_prescale();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h19);
    for (int k = 1; k <= 6; k++) begin
      wait_edges(1);
      if (k >= 2) begin
        read_reg(2'd2, v);
        checks++;
        if (v !== ((k < 4) ? 32'd2 : (k < 6) ? 32'd1 : 32'd0)) begin
          errors++;
          $display("[TB] FAIL ps1_count_e%0d: got %0d", k, v);
        end
      end
      checks++;
      if (irq !== (k == 6)) begin
        errors++;
        $display("[TB] FAIL ps1_irq_e%0d: got %b expected %b", k, irq, (k == 6));
      end
    end
    bus_write(2'd0, 32'h8);
    wait_edges(1);
  endtask
`else
  task automatic test_prescale();
    bus_write(2'd0, 32'hF8);
    read_reg(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("[TB] FAIL ps_unstored: got %h expected %h", v, 32'h8);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    we     = 1'b0;
    addr   = 2'd0;
    wd     = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_mode0();
    test_mode1();
    test_im_masked();
    test_preset_zero();
    test_count_write();
    test_freeze();
    test_back_to_back();
    test_mode_change();
    test_prescale();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
